// File: rtl/montar_pin_pkg.sv
// Shared types and key constants for the keypad entry stage (montar_pin).
// pinPac_t is the packet handed to the PIN verifier.
package montar_pin_pkg;

    typedef struct packed {
        logic       status;
        logic [3:0] digit4;
        logic [3:0] digit3;
        logic [3:0] digit2;
        logic [3:0] digit1;
    } pinPac_t;

    localparam logic [3:0]  KEY_STAR    = 4'hA;
    localparam logic [3:0]  KEY_HASH    = 4'hB;
    localparam logic [3:0]  DIGIT_BLANK = 4'hF;
    localparam logic [15:0] BUF_BLANK   = {4{DIGIT_BLANK}};

    // New digit enters at digit1; the oldest digit4 falls off.
    function automatic logic [15:0] shift_in(input logic [15:0] buf_in, input logic [3:0] d);
        return {buf_in[11:0], d};
    endfunction

endpackage

// File: rtl/montar_pin_contador.sv
// contador_timeout: down-counter reloaded by clr, decremented by en,
// expired once LIMIT-1 enabled cycles have elapsed since the last clear.
module contador_timeout #(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LOAD = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/montar_pin.sv
// Keypad entry stage: collects 4 digits, handles '*'/'#', inactivity timeout,
// and issues a one-cycle submit pulse. Optional macro: MONTAR_PIN_BACKSPACE_EN.
module montar_pin
    import montar_pin_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned HOLD_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        bloqueio,
    output pinPac_t     pin_out,
    output logic [2:0]  digit_count,
    output logic [15:0] disp_digits,
    output logic        entry_err,
    output logic        timeout_evt
);

    typedef enum logic [1:0] {VAZIO, COLETA, ENVIA, ESPERA_VERIF} state_t;

    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] pin_dig_q, pin_dig_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic        tmr_clr, tmr_exp, hold_exp;

    logic is_digit, is_star, is_hash;
    assign is_digit = key_valid && (key_code <= 4'h9);
    assign is_star  = key_valid && (key_code == KEY_STAR);
    assign is_hash  = key_valid && (key_code == KEY_HASH);

    contador_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk(clk), .rst_n(rst), .clr(tmr_clr), .en(state_q == COLETA), .expired(tmr_exp)
    );

    contador_timeout #(.LIMIT(HOLD_CYCLES)) u_hold (
        .clk(clk), .rst_n(rst), .clr(state_q != ESPERA_VERIF),
        .en(state_q == ESPERA_VERIF), .expired(hold_exp)
    );

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        pin_dig_d = pin_dig_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        tmr_clr   = (state_q != COLETA);
        unique case (state_q)
            VAZIO: begin
                if (is_digit) begin
                    buf_d   = shift_in(buf_q, key_code);
                    cnt_d   = 3'd1;
                    state_d = COLETA;
                end
            end
            COLETA: begin
                // Any accepted key takes priority over a same-cycle timer expiry.
                if (is_digit) begin
                    buf_d   = shift_in(buf_q, key_code);
                    cnt_d   = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
                    tmr_clr = 1'b1;
                end else if (is_star) begin
`ifdef MONTAR_PIN_BACKSPACE_EN
                    buf_d   = {DIGIT_BLANK, buf_q[15:4]};
                    cnt_d   = cnt_q - 3'd1;
                    tmr_clr = 1'b1;
                    if (cnt_q == 3'd1) state_d = VAZIO;
`else
                    buf_d   = BUF_BLANK;
                    cnt_d   = 3'd0;
                    state_d = VAZIO;
`endif
                end else if (is_hash) begin
                    if (cnt_q == 3'd4) begin
                        pin_dig_d = buf_q;
                        state_d   = ENVIA;
                    end else begin
                        err_d   = 1'b1;
                        buf_d   = BUF_BLANK;
                        cnt_d   = 3'd0;
                        state_d = VAZIO;
                    end
                end else if (tmr_exp) begin
                    tmo_d   = 1'b1;
                    buf_d   = BUF_BLANK;
                    cnt_d   = 3'd0;
                    state_d = VAZIO;
                end
            end
            ENVIA: state_d = ESPERA_VERIF;
            ESPERA_VERIF: begin
                if (hold_exp) begin
                    buf_d     = BUF_BLANK;
                    pin_dig_d = BUF_BLANK;
                    cnt_d     = 3'd0;
                    state_d   = VAZIO;
                end
            end
            default: state_d = VAZIO;
        endcase
        if (bloqueio) begin
            state_d   = VAZIO;
            buf_d     = BUF_BLANK;
            pin_dig_d = BUF_BLANK;
            cnt_d     = 3'd0;
            err_d     = 1'b0;
            tmo_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= VAZIO;
            buf_q     <= BUF_BLANK;
            pin_dig_q <= BUF_BLANK;
            cnt_q     <= 3'd0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            pin_dig_q <= pin_dig_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        pin_out.status = (state_q == ENVIA);
        {pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1} = pin_dig_q;
    end

    assign digit_count = cnt_q;
    assign disp_digits = buf_q;
    assign entry_err   = err_q;
    assign timeout_evt = tmo_q;

endmodule

// File: tb/tb_montar_pin.sv
// Self-checking bench for montar_pin with a queue-based reference model
// (TIMEOUT_CYCLES=20, HOLD_CYCLES=4).
module tb_montar_pin;
    import montar_pin_pkg::*;

    localparam int TMO  = 20;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        bloqueio = 1'b0;
    pinPac_t     pin_out;
    logic [2:0]  digit_count;
    logic [15:0] disp_digits;
    logic        entry_err;
    logic        timeout_evt;

    montar_pin #(.TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .bloqueio(bloqueio), .pin_out(pin_out), .digit_count(digit_count),
        .disp_digits(disp_digits), .entry_err(entry_err), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: digits held oldest-first, idle cycles while collecting,
    // and cycles remaining in the submit/lockout window (HOLD+1 = status cycle).
    int          q[$];
    int          idle;
    int          busy;
    logic [15:0] m_pin;
    logic        m_err;
    logic        m_tmo;

    function automatic logic [15:0] m_disp();
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < q.size(); i++) r[4*i +: 4] = 4'(q[q.size()-1-i]);
        return r;
    endfunction

    function automatic logic m_status();
        return busy == HOLD + 1;
    endfunction

    task automatic model_reset();
        q.delete();
        idle  = 0;
        busy  = 0;
        m_pin = 16'hFFFF;
        m_err = 1'b0;
        m_tmo = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] c, input logic b);
        bit dig, star, hash;
        dig  = v && (c <= 4'd9);
        star = v && (c == 4'hA);
        hash = v && (c == 4'hB);
        m_err = 1'b0;
        m_tmo = 1'b0;
        if (b) begin
            q.delete(); busy = 0; idle = 0; m_pin = 16'hFFFF;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin q.delete(); m_pin = 16'hFFFF; end
        end else if (q.size() == 0) begin
            if (dig) begin q.push_back(int'(c)); idle = 0; end
        end else if (dig) begin
            q.push_back(int'(c));
            if (q.size() > 4) void'(q.pop_front());
            idle = 0;
        end else if (star) begin
`ifdef MONTAR_PIN_BACKSPACE_EN
            void'(q.pop_back());
            idle = 0;
`else
            q.delete();
`endif
        end else if (hash) begin
            if (q.size() == 4) begin
                m_pin = m_disp();
                busy  = HOLD + 1;
            end else begin
                m_err = 1'b1;
                q.delete();
            end
        end else if (idle == TMO - 1) begin
            m_tmo = 1'b1;
            q.delete();
        end else begin
            idle++;
        end
    endtask

    task automatic tick(input logic v, input logic [3:0] c, input logic b);
        key_valid = v;
        key_code  = c;
        bloqueio  = b;
        @(posedge clk);
        model_step(v, c, b);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        bloqueio  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #12;
        n_checks++; if (pin_out.status !== 1'b0) begin n_fail++; $display("FAIL reset_status: got %b want 0", pin_out.status); end
        n_checks++; if ({pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1} !== 16'hFFFF) begin n_fail++; $display("FAIL reset_pin_digits: got %h want ffff", {pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1}); end
        n_checks++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", digit_count); end
        n_checks++; if (disp_digits !== 16'hFFFF) begin n_fail++; $display("FAIL reset_disp: got %h want ffff", disp_digits); end
        n_checks++; if (entry_err !== 1'b0 || timeout_evt !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got err=%b tmo=%b want 0 0", entry_err, timeout_evt); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_submit();
        int pulses;
        for (int d = 1; d <= 4; d++) tick(1'b1, 4'(d), 1'b0);
        tick(1'b1, 4'hB, 1'b0);
        pulses = int'(pin_out.status);
        n_checks++; if (pin_out.status !== 1'b1) begin n_fail++; $display("FAIL submit_status: got %b want 1", pin_out.status); end
        n_checks++; if ({pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1} !== 16'h1234) begin n_fail++; $display("FAIL submit_digits: got %h want 1234", {pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1}); end
        for (int i = 0; i <= HOLD; i++) begin
            tick(1'b1, 4'($urandom_range(0, 9)), 1'b0);
            pulses += int'(pin_out.status);
            n_checks++; if (pin_out.status !== m_status()) begin n_fail++; $display("FAIL submit_hold_status[%0d]: got %b want %b", i, pin_out.status, m_status()); end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL submit_pulse_count: got %0d want 1", pulses); end
        n_checks++; if (disp_digits !== 16'hFFFF) begin n_fail++; $display("FAIL submit_cleared_disp: got %h want ffff", disp_digits); end
        n_checks++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL submit_cleared_count: got %0d want 0", digit_count); end
    endtask

    task automatic test_entry_err();
        tick(1'b1, 4'h9, 1'b0);
        tick(1'b1, 4'h8, 1'b0);
        tick(1'b1, 4'hB, 1'b0);
        n_checks++; if (entry_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", entry_err); end
        n_checks++; if (pin_out.status !== 1'b0) begin n_fail++; $display("FAIL err_status: got %b want 0", pin_out.status); end
        n_checks++; if (digit_count !== 3'd0 || disp_digits !== 16'hFFFF) begin n_fail++; $display("FAIL err_cleared: got count=%0d disp=%h want 0 ffff", digit_count, disp_digits); end
        tick(1'b0, 4'h0, 1'b0);
        n_checks++; if (entry_err !== 1'b0) begin n_fail++; $display("FAIL err_single: got %b want 0", entry_err); end
    endtask

    task automatic test_overflow();
        for (int d = 1; d <= 6; d++) tick(1'b1, 4'(d), 1'b0);
        n_checks++; if (digit_count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: got %0d want 4", digit_count); end
        tick(1'b1, 4'hB, 1'b0);
        n_checks++; if (pin_out.status !== 1'b1 || {pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1} !== 16'h3456) begin n_fail++; $display("FAIL overflow_submit: got st=%b pin=%h want 1 3456", pin_out.status, {pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1}); end
        for (int i = 0; i <= HOLD; i++) tick(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_timeout();
        tick(1'b1, 4'h5, 1'b0);
        tick(1'b1, 4'h7, 1'b0);
        for (int i = 0; i < TMO; i++) begin
            tick(1'b0, 4'h0, 1'b0);
            n_checks++; if (timeout_evt !== (i == TMO - 1)) begin n_fail++; $display("FAIL timeout_pulse[%0d]: got %b want %b", i, timeout_evt, (i == TMO - 1)); end
        end
        n_checks++; if (digit_count !== 3'd0 || disp_digits !== 16'hFFFF) begin n_fail++; $display("FAIL timeout_cleared: got count=%0d disp=%h want 0 ffff", digit_count, disp_digits); end
        tick(1'b1, 4'h5, 1'b0);
        tick(1'b1, 4'h7, 1'b0);
        for (int i = 0; i < TMO; i++) begin
            tick(i == TMO - 1, 4'h3, 1'b0);
            n_checks++; if (timeout_evt !== 1'b0) begin n_fail++; $display("FAIL timeout_race[%0d]: got %b want 0", i, timeout_evt); end
        end
        n_checks++; if (digit_count !== 3'd3 || disp_digits !== 16'hF573) begin n_fail++; $display("FAIL timeout_race_kept: got count=%0d disp=%h want 3 f573", digit_count, disp_digits); end
        tick(1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_star();
        tick(1'b1, 4'h1, 1'b0);
        tick(1'b1, 4'h2, 1'b0);
        tick(1'b1, 4'hA, 1'b0);
        tick(1'b1, 4'h3, 1'b0);
`ifdef MONTAR_PIN_BACKSPACE_EN
        n_checks++; if (digit_count !== 3'd2 || disp_digits !== 16'hFF13) begin n_fail++; $display("FAIL star_backspace: got count=%0d disp=%h want 2 ff13", digit_count, disp_digits); end
`else
        n_checks++; if (digit_count !== 3'd1 || disp_digits !== 16'hFFF3) begin n_fail++; $display("FAIL star_clear: got count=%0d disp=%h want 1 fff3", digit_count, disp_digits); end
`endif
        tick(1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_bloqueio();
        for (int d = 1; d <= 4; d++) tick(1'b1, 4'(d), 1'b0);
        tick(1'b1, 4'hB, 1'b1);
        n_checks++; if (pin_out.status !== 1'b0) begin n_fail++; $display("FAIL blq_status: got %b want 0", pin_out.status); end
        n_checks++; if (digit_count !== 3'd0 || disp_digits !== 16'hFFFF) begin n_fail++; $display("FAIL blq_cleared: got count=%0d disp=%h want 0 ffff", digit_count, disp_digits); end
        tick(1'b0, 4'h0, 1'b0);
        n_checks++; if (pin_out.status !== 1'b0 || entry_err !== 1'b0) begin n_fail++; $display("FAIL blq_after: got st=%b err=%b want 0 0", pin_out.status, entry_err); end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 4'h1, 1'b0);
        tick(1'b1, 4'h2, 1'b0);
        n_checks++; if (digit_count !== 3'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 2", digit_count); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (digit_count !== 3'd0 || disp_digits !== 16'hFFFF) begin n_fail++; $display("FAIL mid_async_clear: got count=%0d disp=%h want 0 ffff", digit_count, disp_digits); end
        n_checks++; if (pin_out.status !== 1'b0 || entry_err !== 1'b0 || timeout_evt !== 1'b0) begin n_fail++; $display("FAIL mid_async_pulses: got st=%b err=%b tmo=%b want 0 0 0", pin_out.status, entry_err, timeout_evt); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic       v, b;
        logic [3:0] c;
        int         r;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (r < 70)      c = 4'($urandom_range(0, 9));
            else if (r < 85) c = 4'hB;
            else if (r < 90) c = 4'hA;
            else             c = 4'($urandom_range(12, 15));
            b = ($urandom_range(0, 59) == 0);
            tick(v, c, b);
            n_checks++; if (pin_out.status !== m_status()) begin n_fail++; $display("FAIL rnd_status[%0d]: got %b want %b", n, pin_out.status, m_status()); end
            n_checks++; if (digit_count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, digit_count, q.size()); end
            n_checks++; if (disp_digits !== m_disp()) begin n_fail++; $display("FAIL rnd_disp[%0d]: got %h want %h", n, disp_digits, m_disp()); end
            n_checks++; if (entry_err !== m_err || timeout_evt !== m_tmo) begin n_fail++; $display("FAIL rnd_pulses[%0d]: got err=%b tmo=%b want %b %b", n, entry_err, timeout_evt, m_err, m_tmo); end
            if (m_status()) begin
                n_checks++; if ({pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1} !== m_pin) begin n_fail++; $display("FAIL rnd_pin[%0d]: got %h want %h", n, {pin_out.digit4, pin_out.digit3, pin_out.digit2, pin_out.digit1}, m_pin); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_submit();
        test_entry_err();
        test_overflow();
        test_timeout();
        test_star();
        test_bloqueio();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
